// File: rtl/plru_table_pkg.sv
// Shared cache types for the tree-PLRU replacement table: per-set PLRU word,
// way index, and the sweep/ready state encoding.
package plru_table_pkg;

    localparam int ASSOCIATIVITY_DEFAULT = 8;
    localparam int SET_NUM_DEFAULT       = 64;

    typedef logic [ASSOCIATIVITY_DEFAULT-2:0]         plru_t;
    typedef logic [$clog2(ASSOCIATIVITY_DEFAULT)-1:0] associativity_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/plru_table_plru.sv
// 8-way tree-PLRU combinational core: computes the word after touching a way,
// and the victim way selected by a (possibly different) word.
module plru
    import plru_table_pkg::*;
(
    input  plru_t          upd_word_in,
    input  associativity_t upd_way,
    output plru_t          upd_word_out,
    input  plru_t          vic_word,
    output associativity_t victim
);

    logic [2:0] upd_leaf;
    logic [2:0] vic_leaf;
    logic       vic_b2;
    logic       vic_b1;

    // Touching a way points every node on its path away from it.
    always_comb begin
        upd_word_out    = upd_word_in;
        upd_word_out[0] = ~upd_way[2];
        if (upd_way[2]) begin
            upd_word_out[2] = ~upd_way[1];
        end else begin
            upd_word_out[1] = ~upd_way[1];
        end
        upd_leaf               = 3'd3 + {1'b0, upd_way[2:1]};
        upd_word_out[upd_leaf] = ~upd_way[0];
    end

    always_comb begin
        vic_b2   = vic_word[0];
        vic_b1   = vic_word[0] ? vic_word[2] : vic_word[1];
        vic_leaf = 3'd3 + {1'b0, vic_b2, vic_b1};
        victim   = {vic_b2, vic_b1, vic_word[vic_leaf]};
    end

endmodule

// File: rtl/plru_table.sv
// Per-set tree-PLRU state table with a post-reset clearing sweep, one-cycle
// victim lookup, and same-cycle forwarding from a concurrent update.
module plru_table
    import plru_table_pkg::*;
#(
    parameter int ASSOCIATIVITY = ASSOCIATIVITY_DEFAULT,
    parameter int SET_NUM       = SET_NUM_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lookup_valid,
    input  logic [$clog2(SET_NUM)-1:0]   lookup_index,
    input  logic                         update_valid,
    input  logic [$clog2(SET_NUM)-1:0]   update_index,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] update_line,
    output logic                         replace_valid,
    output logic [$clog2(ASSOCIATIVITY)-1:0] replace_line,
    output logic                         init_busy
);

    localparam int IDX_W = $clog2(SET_NUM);

    state_t         state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    plru_t          table_q [SET_NUM];
    plru_t          table_d [SET_NUM];
    logic           replace_valid_q, replace_valid_d;
    associativity_t replace_line_q, replace_line_d;

    plru_t          upd_word;
    plru_t          lkp_word;
    associativity_t victim;
    logic           fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_INIT;
            cnt_q           <= '0;
            replace_valid_q <= 1'b0;
            replace_line_q  <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            replace_valid_q <= replace_valid_d;
            replace_line_q  <= replace_line_d;
        end
    end

    // Contents are only meaningful once the sweep has cleared every set.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(SET_NUM - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_comb begin
        init_busy     = (state_q == ST_INIT);
        replace_valid = replace_valid_q;
        replace_line  = replace_line_q;
    end

    // A same-set update must be visible to the lookup in the same cycle.
    assign fwd      = update_valid && (update_index == lookup_index);
    assign lkp_word = fwd ? upd_word : table_q[lookup_index];

    plru plru (
        .upd_word_in  (table_q[update_index]),
        .upd_way      (update_line),
        .upd_word_out (upd_word),
        .vic_word     (lkp_word),
        .victim       (victim)
    );

    always_comb begin
        table_d = table_q;
        if (state_q == ST_INIT) begin
            table_d[cnt_q] = '0;
        end else if (update_valid) begin
            table_d[update_index] = upd_word;
        end
    end

    always_comb begin
        replace_valid_d = (state_q == ST_READY) && lookup_valid;
        replace_line_d  = replace_valid_d ? victim : replace_line_q;
    end

endmodule

// File: tb/tb_plru_table.sv
// Randomized and directed checks of plru_table against a tree-walk PLRU
// reference model held in the bench.
module tb_plru_table;

    localparam int NS = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       lookup_valid;
    logic [5:0] lookup_index;
    logic       update_valid;
    logic [5:0] update_index;
    logic [2:0] update_line;
    logic       replace_valid;
    logic [2:0] replace_line;
    logic       init_busy;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [6:0] m_tbl [NS];
    int         m_init;
    logic       m_rv;
    logic [2:0] m_rl;

    always #5 clk = ~clk;

    plru_table #(.ASSOCIATIVITY(8), .SET_NUM(NS)) dut (
        .clk           (clk),
        .reset         (reset),
        .lookup_valid  (lookup_valid),
        .lookup_index  (lookup_index),
        .update_valid  (update_valid),
        .update_index  (update_index),
        .update_line   (update_line),
        .replace_valid (replace_valid),
        .replace_line  (replace_line),
        .init_busy     (init_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Heap-ordered tree walk: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
    function automatic logic [2:0] m_victim(input logic [6:0] p);
        int         node = 0;
        logic [2:0] way  = '0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            logic b;
            b    = p[node];
            way  = {way[1:0], b};
            node = 2 * node + 1 + int'(b);
        end
        return way;
    endfunction

    function automatic logic [6:0] m_touch(input logic [6:0] p, input logic [2:0] h);
        int         node = 0;
        logic [6:0] r    = p;
        for (int lvl = 0; lvl < 3; lvl++) begin
            logic b;
            b       = h[2 - lvl];
            r[node] = ~b;
            node    = 2 * node + 1 + int'(b);
        end
        return r;
    endfunction

    task automatic cycle(input bit rst, input bit lv, input int li,
                         input bit uv, input int ui, input int ul);
        logic [6:0] w;
        reset        = rst;
        lookup_valid = lv;
        lookup_index = 6'(li);
        update_valid = uv;
        update_index = 6'(ui);
        update_line  = 3'(ul);
        check_val("init_busy", 32'(init_busy), (m_init > 0) ? 32'd1 : 32'd0);
        if (rst) begin
            m_init = NS;
            m_rv   = 1'b0;
            m_rl   = '0;
            for (int s = 0; s < NS; s++) m_tbl[s] = '0;
        end else if (m_init > 0) begin
            m_init--;
            m_rv = 1'b0;
        end else begin
            w = (uv && ui == li) ? m_touch(m_tbl[ui], 3'(ul)) : m_tbl[li];
            if (uv) m_tbl[ui] = m_touch(m_tbl[ui], 3'(ul));
            m_rv = lv;
            if (lv) m_rl = m_victim(w);
        end
        @(posedge clk);
        #1;
        check_val("replace_valid", 32'(replace_valid), 32'(m_rv));
        check_val("replace_line", 32'(replace_line), 32'(m_rl));
    endtask

    task automatic rand_cycle(input bit rst);
        cycle(rst, 1'($urandom), int'($urandom_range(0, 63)),
              1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
    endtask

    task automatic run_init(input string tag);
        int n = 0;
        while (init_busy && n < 200) begin
            rand_cycle(1'b0);
            n++;
        end
        check_val(tag, 32'(n), 32'd64);
    endtask

    initial begin
        reset        = 1'b1;
        lookup_valid = 1'b0;
        lookup_index = '0;
        update_valid = 1'b0;
        update_index = '0;
        update_line  = '0;
        m_init = NS;
        m_rv   = 1'b0;
        m_rl   = '0;
        for (int s = 0; s < NS; s++) m_tbl[s] = '0;
        @(posedge clk);
        #1;
        rand_cycle(1'b1);
        rand_cycle(1'b1);
        run_init("init_len_first");

        cycle(0, 1, 5, 0, 0, 0);
        check_val("s5_fresh", 32'(replace_line), 32'd0);
        cycle(0, 0, 0, 1, 5, 0);
        cycle(0, 1, 5, 0, 0, 0);
        check_val("s5_after_w0", 32'(replace_line), 32'd4);
        cycle(0, 1, 5, 1, 5, 4);
        check_val("s5_fwd_w4", 32'(replace_line), 32'd2);
        cycle(0, 1, 6, 1, 5, 0);
        check_val("s6_isolated", 32'(replace_line), 32'd0);
        cycle(0, 1, 5, 0, 0, 0);
        check_val("s5_after_s6", 32'(replace_line), 32'd6);
        cycle(0, 0, 9, 0, 0, 0);
        check_val("hold_line", 32'(replace_line), 32'd6);

        rand_cycle(1'b1);
        rand_cycle(1'b1);
        for (int i = 0; i < 30; i++) rand_cycle(1'b0);
        rand_cycle(1'b1);
        run_init("init_len_midsweep");
        cycle(0, 1, 5, 0, 0, 0);
        check_val("s5_after_midsweep", 32'(replace_line), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 999) == 0), 1'($urandom),
                  narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63)),
                  1'($urandom),
                  narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 7)));
        end

        rand_cycle(1'b1);
        run_init("init_len_final");
        cycle(0, 1, 5, 0, 0, 0);
        check_val("s5_after_final_reset", 32'(replace_line), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plru_table.md
PLRU_TABLE -- requirements
Module: plru_table

Interface
REQ-001 Parameter ASSOCIATIVITY, default 8, ways per set; only 8 is supported, so plru state is 7 bits and the way index is 3 bits.
REQ-002 Parameter SET_NUM, default 64, sets per cache; a power of two, at least 2; index width is $clog2(SET_NUM).
REQ-003 clk  input  1  single clock; every state element updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 lookup_valid  input  1  request for the victim way of lookup_index.
REQ-006 lookup_index  input  IDX  set being looked up.
REQ-007 update_valid  input  1  access to a way (hit or refill) is to be recorded.
REQ-008 update_index  input  IDX  set that was accessed.
REQ-009 update_line  input  3  way that was accessed.
REQ-010 replace_valid  output  1  replace_line holds a valid answer this cycle.
REQ-011 replace_line  output  3  victim way for the lookup accepted one cycle earlier.
REQ-012 init_busy  output  1  table is clearing; all requests are ignored.

Function
REQ-013 The table SHALL hold one 7-bit tree-PLRU word per set, in flops, so reads are combinational.
REQ-014 States are INIT and READY; reset forces INIT with sweep counter 0.
REQ-015 In INIT, after reset is released, one set per cycle (set number = counter) SHALL be written to 0; after set SET_NUM-1 is written the block moves to READY.
REQ-016 init_busy SHALL be 1 exactly in INIT; it falls SET_NUM cycles after the first cycle with reset low.
REQ-017 In INIT, lookup_valid and update_valid SHALL be ignored, and replace_valid SHALL be 0.
REQ-018 Lookup latency is 1 cycle: a lookup accepted in cycle t gives replace_valid=1 and replace_line in cycle t+1.
REQ-019 replace_valid SHALL be 0 in any cycle that follows a cycle with no accepted lookup.
REQ-020 replace_line SHALL hold its value when replace_valid is 0.
REQ-021 Victim way encoding:
- bit2 = p[0];
- bit1 = p[0] ? p[2] : p[1];
- bit0 = p[3 + 2*bit2 + bit1].
REQ-022 Update rule for accessed way h. p[0], one level-1 bit and one leaf bit are rewritten; all other bits are kept.
- p[0] <= ~h[2];
- if h[2] then p[2] <= ~h[1], else p[1] <= ~h[1];
- p[3 + 2*h[2] + h[1]] <= ~h[0].
REQ-023 An update accepted in cycle t SHALL write the new word at the edge ending cycle t.
REQ-024 Back-to-back updates to the same set SHALL compose: each one starts from the result of the previous one.
REQ-025 Forwarding: if a lookup and an update target the same set in the same cycle, the victim SHALL be computed from the post-update word.
REQ-026 If a lookup and an update target different sets in the same cycle, the lookup uses the stored word.
REQ-027 Index arithmetic is unsigned, with no wrap beyond SET_NUM-1.
REQ-028 Out-of-range way values cannot occur, since the way index is 3 bits.

Reset
REQ-029 While reset is 1, all of the following SHALL hold and table contents are don't-care until the sweep completes:
- state INIT, counter 0;
- init_busy 1;
- replace_valid 0;
- replace_line 0.
REQ-030 Reset asserted at any point, including mid-sweep or during READY, SHALL restart the full sweep from set 0.

Structure
REQ-031 The plru_t and associativity_t typedefs, and the SET_NUM default, belong in the shared cache package.
REQ-032 The victim and update computation SHALL be done by one instance of the existing 8-way PLRU combinational sub-module, named plru.
REQ-033 That instance is fed the forwarded word; storage, the INIT sweep and the output register are local to plru_table.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Reset 3 cycles, then release -> init_busy=1 for exactly 64 cycles; lookups in that window give replace_valid=0.
- After init, lookup set 5 -> next cycle replace_valid=1, replace_line=0.
- Update set 5 way 0 (word becomes 0x0B), then lookup set 5 -> replace_line=4.
- Then update set 5 way 4 (word becomes 0x2E) in the same cycle as a lookup of set 5 -> replace_line=2 via forwarding.
- Update set 5 way 0 and look up set 6 in the same cycle -> set 6 gives replace_line=0; set 5 is unaffected by set 6 traffic.
- Reset asserted mid-sweep at counter 30, and also after the previous scenarios -> sweep restarts and takes 64 cycles; lookup set 5 afterwards gives replace_line=0.
